// File: rtl/memory_dumper.sv
// Streams a range of program-memory bytes out of a UART transmitter (8N1, LSB first).
// Build option DUMP_ADRS_PREFIX_EN: precede every data byte with a frame carrying its address.
module memory_dumper #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       start,
  input  logic [7:0] first_adrs,
  input  logic [7:0] last_adrs,
  output logic [7:0] mm_adrs,
  input  logic [7:0] mm_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    START_BIT,
    DATA_BITS,
    STOP_BIT
`ifdef DUMP_ADRS_PREFIX_EN
    , ADRS_FRAME
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  adrs_reg, adrs_next;
  logic [7:0]  last_reg, last_next;
  logic [7:0]  shift_reg, shift_next;
  logic [15:0] baud_reg, baud_next;
  logic [3:0]  bit_reg, bit_next;
  logic        tx_reg, tx_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        baud_end;

  assign baud_end = (baud_reg == 16'(CLKS_PER_BIT - 1));

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_reg <= IDLE;
      adrs_reg  <= 8'h00;
      last_reg  <= 8'h00;
      shift_reg <= 8'h00;
      baud_reg  <= 16'h0000;
      bit_reg   <= 4'h0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      adrs_reg  <= adrs_next;
      last_reg  <= last_next;
      shift_reg <= shift_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    adrs_next  = adrs_reg;
    last_next  = last_reg;
    shift_next = shift_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        // A start coinciding with the done pulse is deliberately dropped.
        if (start && !done_reg) begin
          last_next  = last_adrs;
          adrs_next  = first_adrs;
          busy_next  = 1'b1;
          state_next = FETCH_A;
        end
      end
      FETCH_A: state_next = FETCH_B;
      FETCH_B: begin
        shift_next = mm_data;
        baud_next  = 16'h0000;
        bit_next   = 4'h0;
        tx_next    = 1'b0;
`ifdef DUMP_ADRS_PREFIX_EN
        state_next = ADRS_FRAME;
`else
        state_next = START_BIT;
`endif
      end
`ifdef DUMP_ADRS_PREFIX_EN
      ADRS_FRAME: begin
        // bit_reg walks start(0), address bits(1..8), stop(9) of the prefix frame.
        if (baud_end) begin
          baud_next = 16'h0000;
          if (bit_reg == 4'd9) begin
            bit_next   = 4'h0;
            tx_next    = 1'b0;
            state_next = START_BIT;
          end else begin
            bit_next = bit_reg + 4'd1;
            tx_next  = (bit_reg == 4'd8) ? 1'b1 : adrs_reg[bit_reg[2:0]];
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
`endif
      START_BIT: begin
        if (baud_end) begin
          baud_next  = 16'h0000;
          bit_next   = 4'h0;
          tx_next    = shift_reg[0];
          state_next = DATA_BITS;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      DATA_BITS: begin
        if (baud_end) begin
          baud_next  = 16'h0000;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 4'd7) begin
            tx_next    = 1'b1;
            state_next = STOP_BIT;
          end else begin
            bit_next = bit_reg + 4'd1;
            tx_next  = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      STOP_BIT: begin
        if (baud_end) begin
          baud_next = 16'h0000;
          if (adrs_reg == last_reg) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            adrs_next  = adrs_reg + 8'd1;
            state_next = FETCH_A;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mm_adrs = adrs_reg;
  assign tx      = tx_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_memory_dumper.sv
// Self-checking bench for memory_dumper: UART frame monitor feeding a scoreboard,
// table-driven dump ranges, plus hand sequences for reset abort and start/done alignment.
module tb_memory_dumper;

  localparam int CPB = 4;
`ifdef DUMP_ADRS_PREFIX_EN
  localparam int PER = 2 + 20 * CPB;
  localparam int OFS = 10 * CPB;
`else
  localparam int PER = 2 + 10 * CPB;
  localparam int OFS = 0;
`endif

  logic       clock = 1'b0;
  logic       reset_N = 1'b0;
  logic       start = 1'b0;
  logic [7:0] first_adrs = 8'h00;
  logic [7:0] last_adrs = 8'h00;
  logic [7:0] mm_adrs;
  logic [7:0] mm_data;
  logic       tx, busy, done;

  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0] adrs;
    logic [7:0] data;
  } frame_t;

  typedef struct {
    logic [7:0] f;
    logic [7:0] l;
    int         n;
    bit         spam;
  } vec_t;

  frame_t exp_q[$];
  logic   trace[$];
  int     n_checks = 0;
  int     n_fail = 0;

  memory_dumper #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset_N(reset_N), .start(start),
    .first_adrs(first_adrs), .last_adrs(last_adrs),
    .mm_adrs(mm_adrs), .mm_data(mm_data),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) mm_data <= mem[mm_adrs];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [7:0] a);
`ifdef DUMP_ADRS_PREFIX_EN
    exp_q.push_back('{adrs: a, data: a});
`endif
    exp_q.push_back('{adrs: a, data: mem[a]});
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (done !== 1'b1 && k < lim) begin
      @(negedge clock);
      k++;
    end
    if (done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no done within %0d cycles", lim);
    end
  endtask

  // Decodes each UART frame on tx and compares it with the scoreboard head.
  initial begin : monitor
    bit         act;
    int         cnt;
    logic [7:0] sh;
    logic [7:0] fadr;
    frame_t     e;
    act = 0; cnt = 0; sh = 8'h00; fadr = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset_N) begin
        act = 0;
      end else if (!act) begin
        if (tx === 1'b0) begin
          act = 1; cnt = 0; fadr = mm_adrs;
        end
      end else begin
        cnt++;
        if (cnt == CPB - 1) check("start_bit", tx, 1'b0);
        if (cnt >= CPB + 1 && cnt <= 8 * CPB + 1 && (cnt - 1) % CPB == 0) sh = {tx, sh[7:1]};
        if (cnt == 9 * CPB + 1) begin
          check("stop_bit", tx, 1'b1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame: got unexpected byte %0h, required no frame", sh);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", sh, e.data);
            check("frame_adrs", fadr, e.adrs);
          end
          act = 0;
        end
      end
    end
  end

  task automatic run_dump(input logic [7:0] f, input logic [7:0] l, input int n, input bit spam,
                          output int busy_cyc, output int done_cnt);
    logic [7:0] a;
    int cyc, post;
    bit seen;
    a = f;
    for (int i = 0; i < n; i++) begin
      push_exp(a);
      a = a + 8'd1;
    end
    @(negedge clock);
    first_adrs = f; last_adrs = l; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    busy_cyc = 0; done_cnt = 0; cyc = 0; post = 0; seen = 0;
    trace.delete();
    while (post < 4 && cyc <= n * PER + 20) begin
      trace.push_back(tx);
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) done_cnt++;
      if (done === 1'b1) seen = 1;
      if (seen) post++;
      if (spam && cyc < n * PER - 10 && cyc % 3 == 0) begin
        start = 1'b1; first_adrs = 8'($urandom); last_adrs = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no done after %0d cycles, required within %0d", cyc, n * PER + 20);
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t       vecs[5];
    logic [9:0] pat;
    int         bc, dc;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hA5;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    mem[8'h60] = 8'hA5;

    vecs[0] = '{8'h10, 8'h10, 1, 1'b0};
    vecs[1] = '{8'hFE, 8'h01, 4, 1'b0};
    vecs[2] = '{8'h20, 8'h22, 3, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, 256, 1'b0};
    vecs[4] = '{8'h05, 8'h04, 256, 1'b0};
    pat = {1'b1, 8'hA5, 1'b0};

    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_adrs", mm_adrs, 8'h00);
    reset_N = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_dump(vecs[v].f, vecs[v].l, vecs[v].n, vecs[v].spam, bc, dc);
      $display("dump %0h..%0h: busy %0d cycles, %0d done pulses", vecs[v].f, vecs[v].l, bc, dc);
      check("busy_cycles", bc, vecs[v].n * PER);
      check("done_pulses", dc, 1);
      check("queue_empty", exp_q.size(), 0);
      check("busy_after", busy, 1'b0);
      if (v == 0) begin
        check("fetch_tx0", trace[0], 1'b1);
        check("fetch_tx1", trace[1], 1'b1);
        for (int i = 0; i < 10; i++)
          for (int j = 0; j < CPB; j++)
            check("tx_waveform", trace[2 + OFS + CPB * i + j], pat[i]);
      end
    end

    // Start during the done cycle is dropped; held one more cycle it is taken.
    push_exp(8'h40);
    @(negedge clock);
    first_adrs = 8'h40; last_adrs = 8'h40; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(PER + 20);
    first_adrs = 8'h41; last_adrs = 8'h41; start = 1'b1;
    push_exp(8'h41);
    @(negedge clock);
    check("start_on_done_ignored", busy, 1'b0);
    @(negedge clock);
    start = 1'b0;
    check("start_after_done_taken", busy, 1'b1);
    @(negedge clock);
    wait_done(PER + 20);
    repeat (3) @(negedge clock);
    check("queue_empty_done_align", exp_q.size(), 0);
    $display("done/start alignment sequence complete");

    // Abort mid-frame during the fifth data bit of 0xA5 (a zero bit).
`ifdef DUMP_ADRS_PREFIX_EN
    exp_q.push_back('{adrs: 8'h60, data: 8'h60});
`endif
    @(negedge clock);
    first_adrs = 8'h60; last_adrs = 8'h61; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (23 + OFS) @(negedge clock);
    check("tx_before_abort", tx, 1'b0);
    #2 reset_N = 1'b0;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_adrs", mm_adrs, 8'h00);
    repeat (3) @(negedge clock);
    check("queue_empty_abort", exp_q.size(), 0);
    push_exp(8'h60);
    push_exp(8'h61);
    reset_N = 1'b1;
    first_adrs = 8'h60; last_adrs = 8'h61; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("first_start_after_reset", busy, 1'b1);
    wait_done(2 * PER + 20);
    repeat (3) @(negedge clock);
    check("queue_empty_after_redump", exp_q.size(), 0);
    check("busy_after_redump", busy, 1'b0);
    $display("reset abort sequence complete");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_dumper.md
MEMORY_DUMPER -- requirements
Module: memory_dumper

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 SHALL have port clock  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  synchronous request pulse; sampled only in IDLE.
REQ-005 SHALL have port first_adrs  input  8  first memory address to dump; latched on accepted start.
REQ-006 SHALL have port last_adrs  input  8  last memory address to dump; latched on accepted start.
REQ-007 SHALL have port mm_adrs  output  8  registered read address to program memory.
REQ-008 SHALL have port mm_data  input  8  memory read data (q); valid from the second rising edge after mm_adrs changes.
REQ-009 SHALL have port tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-010 SHALL have port busy  output  1  high from accepted start until dump completes.
REQ-011 SHALL have port done  output  1  one-cycle pulse at completion.

Function
REQ-012 SHALL implement FSM states IDLE, FETCH_A, FETCH_B, START_BIT, DATA_BITS, STOP_BIT, plus ADRS_FRAME when the configuration macro is defined.
REQ-013 In IDLE with start=1: latch first/last, mm_adrs<=first_adrs, busy<=1, go to FETCH_A.
REQ-014 FETCH_A -> FETCH_B unconditionally; at the FETCH_B edge, capture mm_data into the shift register and go to START_BIT (or ADRS_FRAME).
REQ-015 Each bit period SHALL last exactly CLKS_PER_BIT cycles; frame = start bit (0), 8 data bits LSB first, stop bit (1) = 10*CLKS_PER_BIT cycles.
REQ-016 At the end of STOP_BIT: if current address == latched last, go to IDLE, busy<=0, done<=1 for one cycle; else mm_adrs<=mm_adrs+1 (mod 256), go to FETCH_A.
REQ-017 Address increment SHALL wrap 0xFF -> 0x00; last_adrs < first_adrs dumps through the wrap (e.g. 0xFE..0x01 = 4 bytes).
REQ-018 first_adrs == last_adrs SHALL dump exactly one byte; first=0x00,last=0xFF and first=last+1 SHALL each dump 256 bytes.
REQ-019 start while busy=1 SHALL be ignored; first_adrs/last_adrs changes after acceptance SHALL have no effect.
REQ-020 tx SHALL be glitch-free: driven from a register, high in all states except start bit and 0-valued data bits.
REQ-021 A start asserted in the same cycle done pulses SHALL be ignored; a start in the following cycle SHALL be accepted.
REQ-022 The block SHALL never write memory (no write-enable output).

Reset
REQ-023 While reset_N=0: state=IDLE, tx=1, busy=0, done=0, mm_adrs=0x00, bit/baud counters and shift register=0.
REQ-024 Reset asserted mid-frame SHALL abort immediately (tx high asynchronously); no partial resume after release.
REQ-025 First start SHALL be accepted on the first rising edge after reset_N deasserts.

Configuration
REQ-026 Macro DUMP_ADRS_PREFIX_EN: when defined, each data byte SHALL be preceded by a full 8N1 frame carrying its address (ADRS_FRAME state), doubling per-byte time to 20*CLKS_PER_BIT cycles plus fetch.
REQ-027 When DUMP_ADRS_PREFIX_EN is undefined, only data frames SHALL be sent and ADRS_FRAME logic SHALL not exist.

Verification (CLKS_PER_BIT=4, synchronous-read memory model)
REQ-028 Mem[0x10]=0xA5, start first=last=0x10 -> tx: 0,1,0,1,0,0,1,0,1,1 each 4 cycles; done one pulse; busy low after.
REQ-029 Mem[0xFE..0x01]=0x11,0x22,0x33,0x44, first=0xFE,last=0x01 -> 4 frames in order 11,22,33,44; mm_adrs sequence FE,FF,00,01.
REQ-030 Start pulses repeated during a 3-byte dump -> exactly 3 frames, one done pulse, latched range unchanged.
REQ-031 reset_N low during 5th data bit -> tx=1 immediately, busy=0; new start after release dumps from first_adrs again.
REQ-032 first=0x00,last=0xFF -> 256 frames, total busy time 256*(2+40) cycles (+/-1 for start/done alignment).
REQ-033 With DUMP_ADRS_PREFIX_EN, first=last=0x3C, Mem[0x3C]=0x7E -> frames 0x3C then 0x7E, done after both.
